// File: rtl/reaction_round_ctrl_if.sv
// Reaction round controller bus.
// Groups the game-control inputs (tick, start, hit, abort, rand_val) and the
// status outputs (rand_req, state, go, round_idx, result, last_time,
// best_time, hit_cnt, done) consumed by the screen-select logic.
//   slave  : the controller side (drives status, receives control)
//   master : the game / stimulus side (drives control, receives status)
interface reaction_round_ctrl_if;
    logic       tick;
    logic       start;
    logic       hit;
    logic       abort;
    logic [8:0] rand_val;

    logic       rand_req;
    logic [2:0] state;
    logic       go;
    logic [2:0] round_idx;
    logic [1:0] result;
    logic [8:0] last_time;
    logic [8:0] best_time;
    logic [2:0] hit_cnt;
    logic       done;

    modport slave (
        input  tick, start, hit, abort, rand_val,
        output rand_req, state, go, round_idx, result, last_time, best_time, hit_cnt, done
    );

    modport master (
        output tick, start, hit, abort, rand_val,
        input  rand_req, state, go, round_idx, result, last_time, best_time, hit_cnt, done
    );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-time game sequencer.
// Each round: ARM loads a random delay (floored at MIN_DELAY), WAIT counts it
// down on 100 Hz ticks, ACTIVE raises go and counts reaction ticks until hit
// or TIMEOUT, RESULT holds for RESULT_HOLD ticks. After NUM_ROUNDS rounds the
// game parks in DONE. False starts, misses and the best HIT time are tracked.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : reaction_round_ctrl_if.slave (control inputs, status outputs)
module reaction_round_ctrl #(
    parameter int unsigned NUM_ROUNDS  = 3,
    parameter logic [8:0]  MIN_DELAY   = 9'd100,
    parameter logic [8:0]  TIMEOUT     = 9'd300,
    parameter logic [7:0]  RESULT_HOLD = 8'd100
) (
    input logic                     clk,
    input logic                     rst_n,
    reaction_round_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArm    = 3'd1,
        StWait   = 3'd2,
        StActive = 3'd3,
        StResult = 3'd4,
        StDone   = 3'd5
    } state_e;

    localparam logic [1:0] ResNone  = 2'd0;
    localparam logic [1:0] ResHit   = 2'd1;
    localparam logic [1:0] ResFalse = 2'd2;
    localparam logic [1:0] ResMiss  = 2'd3;

    localparam logic [2:0] LastRound = 3'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [2:0] round_q, round_d;
    logic [1:0] result_q, result_d;
    logic [8:0] last_q, last_d;
    logic [8:0] best_q, best_d;
    logic [2:0] hit_cnt_q, hit_cnt_d;
    logic [8:0] delay_q, delay_d;
    logic [8:0] react_q, react_d;
    logic [7:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            round_q   <= '0;
            result_q  <= ResNone;
            last_q    <= '0;
            best_q    <= 9'h1FF;
            hit_cnt_q <= '0;
            delay_q   <= '0;
            react_q   <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            result_q  <= result_d;
            last_q    <= last_d;
            best_q    <= best_d;
            hit_cnt_q <= hit_cnt_d;
            delay_q   <= delay_d;
            react_q   <= react_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        result_d  = result_q;
        last_d    = last_q;
        best_d    = best_q;
        hit_cnt_d = hit_cnt_q;
        delay_d   = delay_q;
        react_d   = react_q;
        hold_d    = hold_q;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_d   = StArm;
                        round_d   = '0;
                        hit_cnt_d = '0;
                        result_d  = ResNone;
                        last_d    = '0;
                        best_d    = 9'h1FF;
                    end
                end
                StArm: begin
                    // Floored delay guarantees delay_cnt >= 1 in WAIT.
                    delay_d = (bus.rand_val < MIN_DELAY) ? bus.rand_val + MIN_DELAY
                                                         : bus.rand_val;
                    state_d = StWait;
                end
                StWait: begin
                    // A hit beats a coincident final tick.
                    if (bus.hit) begin
                        state_d  = StResult;
                        result_d = ResFalse;
                        last_d   = 9'h1FF;
                        hold_d   = '0;
                    end else if (bus.tick) begin
                        delay_d = delay_q - 9'd1;
                        if (delay_q == 9'd1) begin
                            state_d = StActive;
                            react_d = '0;
                        end
                    end
                end
                StActive: begin
                    // A hit beats a coincident timeout tick and scores the
                    // pre-increment count.
                    if (bus.hit) begin
                        state_d  = StResult;
                        result_d = ResHit;
                        last_d   = react_q;
                        hold_d   = '0;
                        if (hit_cnt_q != 3'd7) begin
                            hit_cnt_d = hit_cnt_q + 3'd1;
                        end
                        if (react_q < best_q) begin
                            best_d = react_q;
                        end
                    end else if (bus.tick) begin
                        if (react_q == TIMEOUT - 9'd1) begin
                            state_d  = StResult;
                            result_d = ResMiss;
                            last_d   = TIMEOUT;
                            hold_d   = '0;
                        end else begin
                            react_d = react_q + 9'd1;
                        end
                    end
                end
                StResult: begin
                    if (bus.tick) begin
                        if (hold_q == RESULT_HOLD - 8'd1) begin
                            if (round_q == LastRound) begin
                                state_d = StDone;
                            end else begin
                                state_d = StArm;
                                round_d = round_q + 3'd1;
                            end
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.state     = state_q;
        bus.go        = (state_q == StActive);
        bus.rand_req  = (state_q == StArm);
        bus.done      = (state_q == StDone);
        bus.round_idx = round_q;
        bus.result    = result_q;
        bus.last_time = last_q;
        bus.best_time = best_q;
        bus.hit_cnt   = hit_cnt_q;
    end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Self-checking bench for reaction_round_ctrl with default parameters
// (3 rounds, MIN_DELAY 100, TIMEOUT 300, RESULT_HOLD 100). Ticks are applied
// on consecutive clocks to keep the run short.
module tb_reaction_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rr_cnt = 0;

    reaction_round_ctrl_if bus ();

    reaction_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Count rand_req pulses mid-cycle.
    always @(negedge clk) if (rst_n && bus.rand_req) rr_cnt++;

    // One record per round: stimulus plus expected RESULT-state outputs.
    typedef struct {
        int rv;        // rand_val presented in ARM
        int w;         // ticks from WAIT entry to go (0: false start, no go)
        int n;         // ticks applied before the hit (or until timeout)
        bit do_hit;
        bit tk;        // hit coincides with a tick
        int res;
        int last;
        int best;
        int hc;
        int rd;        // expected round_idx
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit h, input bit s);
        @(negedge clk);
        bus.tick  = t;
        bus.hit   = h;
        bus.start = s;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.hit   = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic play_round(input int i, input vec_t v);
        string p;
        p = $sformatf("r%0d", i);
        chk({p, "_arm_state"}, int'(bus.state), 1);
        chk({p, "_round_idx"}, int'(bus.round_idx), v.rd);
        chk({p, "_rand_req"}, int'(bus.rand_req), 1);
        bus.rand_val = 9'(v.rv);
        cyc(1'b1, 1'b0, 1'b0);  // tick in ARM must be dropped
        chk({p, "_wait_state"}, int'(bus.state), 2);
        if (v.w != 0) begin
            repeat (v.w - 1) cyc(1'b1, 1'b0, 1'b0);
            chk({p, "_go_early"}, int'(bus.go), 0);
            cyc(1'b1, 1'b0, 1'b0);
            chk({p, "_go_rise"}, int'(bus.go), 1);
            chk({p, "_active_state"}, int'(bus.state), 3);
        end
        repeat (v.n) cyc(1'b1, 1'b0, 1'b0);
        if (v.do_hit) cyc(v.tk, 1'b1, 1'b0);
        chk({p, "_res_state"}, int'(bus.state), 4);
        chk({p, "_res_go"}, int'(bus.go), 0);
        chk({p, "_result"}, int'(bus.result), v.res);
        chk({p, "_last_time"}, int'(bus.last_time), v.last);
        chk({p, "_best_time"}, int'(bus.best_time), v.best);
        chk({p, "_hit_cnt"}, int'(bus.hit_cnt), v.hc);
        cyc(1'b0, 1'b1, 1'b0);  // hit ignored in RESULT
        repeat (99) cyc(1'b1, 1'b0, 1'b0);
        chk({p, "_hold"}, int'(bus.state), 4);
        cyc(1'b1, 1'b0, 1'b0);
        chk({p, "_after_hold"}, int'(bus.state), (v.rd == 2) ? 5 : 1);
        chk({p, "_result_kept"}, int'(bus.result), v.res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          rv   w    n    hit tk res last best hc rd
        vecs[0] = '{40,  140, 37,  1, 0, 1, 37,  37,  1, 0};
        vecs[1] = '{250, 250, 52,  1, 0, 1, 52,  37,  2, 1};
        vecs[2] = '{200, 0,   10,  1, 0, 2, 511, 37,  2, 2};
        vecs[3] = '{120, 0,   119, 1, 1, 2, 511, 511, 0, 0};
        vecs[4] = '{99,  199, 300, 0, 0, 3, 300, 511, 0, 1};
        vecs[5] = '{0,   100, 299, 1, 1, 1, 299, 299, 1, 2};
        vecs[6] = '{100, 100, 20,  1, 0, 1, 20,  20,  1, 0};
        vecs[7] = '{101, 101, 15,  1, 0, 1, 15,  15,  2, 1};
        vecs[8] = '{300, 300, 30,  1, 0, 1, 30,  15,  3, 2};
        vecs[9] = '{5,   105, 5,   1, 0, 1, 5,   5,   1, 0};

        bus.tick = 1'b0;
        bus.start = 1'b0;
        bus.hit = 1'b0;
        bus.abort = 1'b0;
        bus.rand_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_go", int'(bus.go), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rand_req", int'(bus.rand_req), 0);
        chk("rst_best", int'(bus.best_time), 'h1FF);
        chk("rst_last", int'(bus.last_time), 0);
        chk("rst_hit_cnt", int'(bus.hit_cnt), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_round", int'(bus.round_idx), 0);

        cyc(1'b1, 1'b1, 1'b0);
        chk("idle_hit_ignored_state", int'(bus.state), 0);
        chk("idle_hit_ignored_result", int'(bus.result), 0);

        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            play_round(i, vecs[i]);
            if (vecs[i].rd == 2) begin
                chk($sformatf("r%0d_done", i), int'(bus.done), 1);
                chk($sformatf("r%0d_done_round", i), int'(bus.round_idx), 2);
                if (i == 8) chk("rand_req_pulses", rr_cnt, 9);
                cyc(1'b0, 1'b0, 1'b1);
                chk($sformatf("r%0d_restart_state", i), int'(bus.state), 1);
                chk($sformatf("r%0d_restart_best", i), int'(bus.best_time), 'h1FF);
                chk($sformatf("r%0d_restart_hc", i), int'(bus.hit_cnt), 0);
                chk($sformatf("r%0d_restart_done", i), int'(bus.done), 0);
            end
        end

        // Reset mid-WAIT of round 1 after a HIT in round 0.
        bus.rand_val = 9'd60;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_rst_state", int'(bus.state), 2);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_go", int'(bus.go), 0);
        chk("arst_best", int'(bus.best_time), 'h1FF);
        chk("arst_hit_cnt", int'(bus.hit_cnt), 0);
        chk("arst_round", int'(bus.round_idx), 0);
        chk("arst_last", int'(bus.last_time), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post_rst_state", int'(bus.state), 0);

        // Abort from ACTIVE; start in ACTIVE is ignored.
        cyc(1'b0, 1'b0, 1'b1);
        bus.rand_val = 9'd0;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (100) cyc(1'b1, 1'b0, 1'b0);
        chk("abort_pre_go", int'(bus.go), 1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("start_in_active", int'(bus.state), 3);
        @(negedge clk) bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_state", int'(bus.state), 0);
        chk("abort_go", int'(bus.go), 0);
        chk("abort_done", int'(bus.done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
